// File: rtl/votador_secuencial_if.sv
// rtl/votador_secuencial_if.sv - session control and result bundle of the sequential voter (quorum_ok with VOTADOR_QUORUM_EN)
interface votador_secuencial_if #(
    parameter int N = 5
);
    localparam int CW = $clog2(N + 1);

    logic          start;
    logic [N-1:0]  emitir;
    logic [N-1:0]  voto;
    logic          ocupado;
    logic          listo;
    logic          v;
    logic          empate;
    logic [CW-1:0] cuenta_si;
    logic [CW-1:0] cuenta_emitidos;
`ifdef VOTADOR_QUORUM_EN
    logic          quorum_ok;

    modport master (
        output start, emitir, voto,
        input  ocupado, listo, v, empate, cuenta_si, cuenta_emitidos, quorum_ok
    );

    modport slave (
        input  start, emitir, voto,
        output ocupado, listo, v, empate, cuenta_si, cuenta_emitidos, quorum_ok
    );
`else
    modport master (
        output start, emitir, voto,
        input  ocupado, listo, v, empate, cuenta_si, cuenta_emitidos
    );

    modport slave (
        input  start, emitir, voto,
        output ocupado, listo, v, empate, cuenta_si, cuenta_emitidos
    );
`endif

endinterface

// File: rtl/votador_secuencial.sv
// rtl/votador_secuencial.sv - N-voter timed majority voter; optional quorum gating with VOTADOR_QUORUM_EN
module votador_secuencial #(
    parameter int N = 5,
    parameter int T = 16,
    parameter int Q = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    votador_secuencial_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam int TW = (T > 1) ? $clog2(T) : 1;

    if (N < 2 || T < 1 || Q < 1 || Q > N) begin : g_param_invalid
        $error("votador_secuencial: invalid N/T/Q");
    end

    typedef enum logic [1:0] {REPOSO, VOTACION, RECUENTO, RESULTADO} estado_t;

    estado_t       estado, estado_sig;
    logic [N-1:0]  emitido, valor;
    logic [N-1:0]  captura, emitido_sig, valor_sig;
    logic [TW-1:0] timer;

    logic          listo_q, v_q, empate_q;
    logic [CW-1:0] cuenta_si_q, cuenta_emitidos_q;
    logic [CW-1:0] si_calc, emitidos_calc, no_calc;
    logic          v_calc, empate_calc;
`ifdef VOTADOR_QUORUM_EN
    logic          quorum_ok_q, quorum_calc;
`endif

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] x);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + CW'(x[i]);
        end
        return s;
    endfunction

    // Only a voter's first strobe in the session is latched.
    assign captura     = bus.emitir & ~emitido;
    assign emitido_sig = emitido | bus.emitir;
    assign valor_sig   = (valor & ~captura) | (bus.voto & captura);

    always_comb begin
        si_calc       = popcount(valor & emitido);
        emitidos_calc = popcount(emitido);
        no_calc       = emitidos_calc - si_calc;
        v_calc        = (si_calc > no_calc);
        empate_calc   = (si_calc == no_calc);
`ifdef VOTADOR_QUORUM_EN
        quorum_calc   = (emitidos_calc >= CW'(Q));
        if (!quorum_calc) begin
            v_calc      = 1'b0;
            empate_calc = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO, RESULTADO: begin
                if (bus.start) begin
                    estado_sig = VOTACION;
                end
            end
            VOTACION: begin
                if (timer == '0 || (&emitido_sig)) begin
                    estado_sig = RECUENTO;
                end
            end
            RECUENTO: estado_sig = RESULTADO;
            default:  estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            emitido           <= '0;
            valor             <= '0;
            timer             <= '0;
            listo_q           <= 1'b0;
            v_q               <= 1'b0;
            empate_q          <= 1'b0;
            cuenta_si_q       <= '0;
            cuenta_emitidos_q <= '0;
`ifdef VOTADOR_QUORUM_EN
            quorum_ok_q       <= 1'b0;
`endif
        end else begin
            case (estado)
                REPOSO, RESULTADO: begin
                    if (bus.start) begin
                        emitido           <= '0;
                        valor             <= '0;
                        timer             <= TW'(T - 1);
                        listo_q           <= 1'b0;
                        v_q               <= 1'b0;
                        empate_q          <= 1'b0;
                        cuenta_si_q       <= '0;
                        cuenta_emitidos_q <= '0;
`ifdef VOTADOR_QUORUM_EN
                        quorum_ok_q       <= 1'b0;
`endif
                    end
                end
                VOTACION: begin
                    emitido <= emitido_sig;
                    valor   <= valor_sig;
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                end
                RECUENTO: begin
                    listo_q           <= 1'b1;
                    v_q               <= v_calc;
                    empate_q          <= empate_calc;
                    cuenta_si_q       <= si_calc;
                    cuenta_emitidos_q <= emitidos_calc;
`ifdef VOTADOR_QUORUM_EN
                    quorum_ok_q       <= quorum_calc;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ocupado         = (estado == VOTACION) || (estado == RECUENTO);
    assign bus.listo           = listo_q;
    assign bus.v               = v_q;
    assign bus.empate          = empate_q;
    assign bus.cuenta_si       = cuenta_si_q;
    assign bus.cuenta_emitidos = cuenta_emitidos_q;
`ifdef VOTADOR_QUORUM_EN
    assign bus.quorum_ok       = quorum_ok_q;
`endif

endmodule

// File: tb/tb_votador_secuencial.sv
// tb/tb_votador_secuencial.sv - scoreboard bench for votador_secuencial (N=5, T=16, Q=3; honours VOTADOR_QUORUM_EN)
module tb_votador_secuencial;
    localparam int N = 5;
    localparam int T = 16;
    localparam int Q = 3;

    typedef struct {
        int v;
        int empate;
        int cs;
        int ce;
        int qok;
        int lat;
    } esperado_t;

    logic clk = 1'b0;
    logic reset_n;
    int   ciclo = 0;
    int   vectores = 0;
    int   fallos = 0;
    esperado_t cola[$];

    logic ocupado_prev = 1'b0;
    logic listo_prev   = 1'b0;
    int   inicio       = 0;

    votador_secuencial_if #(.N(N)) bus ();

    votador_secuencial #(.N(N), .T(T), .Q(Q)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        vectores++;
        if (actual !== esperado) begin
            fallos++;
            $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
        end
    endtask

    task automatic empujar(input int v, input int e, input int cs, input int ce, input int q, input int lat);
        esperado_t x;
        x.v = v; x.empate = e; x.cs = cs; x.ce = ce; x.qok = q; x.lat = lat;
        cola.push_back(x);
    endtask

    task automatic abrir();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic votar(input logic [N-1:0] e, input logic [N-1:0] val);
        bus.emitir = e;
        bus.voto   = val;
        @(negedge clk);
        bus.emitir = '0;
        bus.voto   = '0;
    endtask

    task automatic esperar_listo(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (bus.listo) break;
            @(negedge clk);
        end
        if (i == max) check("listo timeout", 0, 1);
    endtask

    // Monitor: each rising listo consumes one scoreboard entry.
    initial begin
        esperado_t x;
        forever begin
            @(negedge clk);
            if (bus.ocupado && !ocupado_prev) inicio = ciclo;
            if (bus.listo && !listo_prev) begin
                if (cola.size() == 0) begin
                    check("unexpected result", 1, 0);
                end else begin
                    x = cola.pop_front();
                    check("v", 32'(bus.v), x.v);
                    check("empate", 32'(bus.empate), x.empate);
                    check("cuenta_si", 32'(bus.cuenta_si), x.cs);
                    check("cuenta_emitidos", 32'(bus.cuenta_emitidos), x.ce);
                    check("latency", ciclo - inicio, x.lat);
`ifdef VOTADOR_QUORUM_EN
                    check("quorum_ok", 32'(bus.quorum_ok), x.qok);
`endif
                end
            end
            ocupado_prev = bus.ocupado;
            listo_prev   = bus.listo;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.emitir = '0;
        bus.voto   = '0;
        repeat (2) @(negedge clk);
        check("reset ocupado", 32'(bus.ocupado), 0);
        check("reset listo", 32'(bus.listo), 0);
        bus.start = 1'b1;
        @(negedge clk);
        check("start under reset", 32'(bus.ocupado), 0);
        bus.start = 1'b0;
        reset_n   = 1'b1;

        // Early close: all five vote at edge k+1.
        empujar(1, 0, 3, 5, 1, 2);
        abrir();
        votar(5'b11111, 5'b00111);
        esperar_listo(25);

        // Asynchronous reset while results are held.
        #2 reset_n = 1'b0;
        #1;
        check("async rst listo", 32'(bus.listo), 0);
        check("async rst v", 32'(bus.v), 0);
        check("async rst cuenta_si", 32'(bus.cuenta_si), 0);
        check("async rst cuenta_emitidos", 32'(bus.cuenta_emitidos), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Duplicate vote from voter 0: first (0) is kept.
        empujar(0, 0, 2, 5, 1, 3);
        abrir();
        votar(5'b00001, 5'b00000);
        votar(5'b11111, 5'b10011);
        esperar_listo(25);

        // Timeout with a 1-1 tie.
`ifdef VOTADOR_QUORUM_EN
        empujar(0, 0, 1, 2, 0, T + 1);
`else
        empujar(0, 1, 1, 2, 0, T + 1);
`endif
        abrir();
        votar(5'b00010, 5'b00010);
        @(negedge clk);
        votar(5'b01000, 5'b00000);
        esperar_listo(25);

        // Reset during VOTACION aborts with no result.
        abrir();
        votar(5'b00111, 5'b00111);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort ocupado", 32'(bus.ocupado), 0);
        check("abort listo", 32'(bus.listo), 0);
        @(negedge clk);
        reset_n = 1'b1;
        empujar(0, 0, 2, 5, 1, 2);
        abrir();
        votar(5'b11111, 5'b11000);
        esperar_listo(25);

        // start held during VOTACION must not restart the session.
`ifdef VOTADOR_QUORUM_EN
        empujar(0, 0, 1, 2, 0, T + 1);
`else
        empujar(0, 1, 1, 2, 0, T + 1);
`endif
        abrir();
        bus.start = 1'b1;
        votar(5'b00001, 5'b00001);
        votar(5'b00010, 5'b00000);
        votar(5'b00001, 5'b00000);
        bus.start = 1'b0;
        esperar_listo(25);

        // Strobes in RESULTADO are ignored and results are held.
        bus.emitir = 5'b11111;
        bus.voto   = 5'b11111;
        repeat (3) @(negedge clk);
        bus.emitir = '0;
        bus.voto   = '0;
        check("hold listo", 32'(bus.listo), 1);
        check("hold cuenta_si", 32'(bus.cuenta_si), 1);
        check("hold cuenta_emitidos", 32'(bus.cuenta_emitidos), 2);

        // start in RESULTADO clears results and opens a new session.
        empujar(1, 0, 5, 5, 1, 2);
        abrir();
        check("restart listo", 32'(bus.listo), 0);
        check("restart cuenta_si", 32'(bus.cuenta_si), 0);
        check("restart cuenta_emitidos", 32'(bus.cuenta_emitidos), 0);
        check("restart ocupado", 32'(bus.ocupado), 1);
        votar(5'b11111, 5'b11111);
        esperar_listo(25);

        repeat (3) @(negedge clk);
        check("scoreboard drained", cola.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule

// File: doc/votador_secuencial.md
# votador_secuencial

Parametrised sequential majority voter: a generalisation of the combinational 3-input voter to N voters, with timed voting sessions. A session is opened with a start pulse, each voter's first vote is latched, and the session closes on timeout or when every voter has voted. The result (majority, tie, counts) is then registered and held until the next session. It sits between per-voter input logic and a result display or controller.

## Interface
- N, 5: number of voters, ≥ 2.
- T, 16: maximum session length in clock cycles, ≥ 1.
- Q, 3: quorum, the minimum number of cast votes, 1..N; used only with VOTADOR_QUORUM_EN.
- CW (localparam), $clog2(N+1): width of the count outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  opens a session.
- emitir  in  N  per-voter strobe; bit i high means voter i is casting a vote this cycle.
- voto  in  N  vote value for voter i, sampled where emitir[i] is high.
- ocupado  out  1  session open (VOTACION or RECUENTO).
- listo  out  1  result valid.
- v  out  1  majority result.
- empate  out  1  tie.
- cuenta_si  out  CW  number of yes votes.
- cuenta_emitidos  out  CW  number of votes cast.
- quorum_ok  out  1  quorum reached; exists only with VOTADOR_QUORUM_EN.

## Operation
- There are four states: REPOSO, VOTACION, RECUENTO, RESULTADO.
- Reset (reset_n low) applies asynchronously:
  - state goes to REPOSO;
  - every output is 0;
  - the per-voter registers emitido[N] and valor[N] are cleared;
  - the timer is cleared.
- REPOSO or RESULTADO with start=1 → VOTACION:
  - emitido and valor are cleared;
  - the timer is loaded with T-1;
  - listo, v, empate, the counts and quorum_ok are cleared.
- In VOTACION, each rising edge does the following:
  - For each i, if emitir[i] && !emitido[i], then valor[i] ← voto[i] and emitido[i] ← 1.
  - A second vote from the same voter is ignored: first vote wins.
  - The timer decrements.
  - The state moves to RECUENTO on the same edge if the timer is 0, or if every emitido bit is set after including this edge's captures.
- start is ignored in VOTACION and RECUENTO.
- RECUENTO lasts exactly 1 cycle. Its edge registers the results and moves to RESULTADO with listo=1:
  - cuenta_si = popcount(valor & emitido);
  - cuenta_emitidos = popcount(emitido);
  - no = cuenta_emitidos − cuenta_si.
- Result rules:
  - v = 1 iff cuenta_si > no (strict majority of cast votes).
  - empate = 1 iff cuenta_si == no; this includes zero votes cast.
- RESULTADO holds all outputs until start or reset.
- Widths: the counts never exceed N, so CW bits suffice with no overflow.

## Timing
- The start edge is k; ocupado=1 after edge k.
- Votes are sampled on edges k+1 … k+T, at most T sampling edges.
- The closing edge is e:
  - it samples votes and enters RECUENTO;
  - at edge e+1, listo=1, ocupado=0 and the results are valid.
- Timeout case: e = k+T, so listo rises at edge k+T+1.
- Early close: all N voting at edge k+1 gives listo at edge k+2.
- emitir and voto must be stable around the sampling edge. emitir outside VOTACION has no effect.
- Reset mid-session aborts immediately. No partial result is produced.

## Configuration
- VOTADOR_QUORUM_EN defined:
  - adds the quorum_ok port;
  - quorum_ok = (cuenta_emitidos ≥ Q), registered at the same RECUENTO edge as the other results;
  - if the quorum is not met, v=0 and empate=0 are forced, while the counts are still reported.
- VOTADOR_QUORUM_EN undefined: there is no quorum_ok port, Q is unused, and the results follow the base rules.

## Test plan
(N=5, T=16, Q=3)
- Reset: assert reset_n=0 mid-cycle → all outputs 0 immediately; state REPOSO; start ignored while reset_n=0.
- Early close: start at edge 0; emitir=5'b11111 and voto=5'b00111 at edge 1 → listo=1 after edge 2, v=1, cuenta_si=3, cuenta_emitidos=5, empate=0.
- Duplicate vote: voter 0 votes 0 at edge 1 and 1 at edge 2; the others vote 1,0,0,1 → cuenta_si=2 and v=0, proving the first vote is kept.
- Timeout with tie: only voters 1 (yes) and 3 (no) vote → listo at edge 17, empate=1, v=0, cuenta_emitidos=2; with VOTADOR_QUORUM_EN, quorum_ok=0.
- Reset mid-session: reset_n=0 at edge 5 of VOTACION → ocupado=0 and listo=0; a new session then counts only new votes.
- Control: start during VOTACION has no effect on the timer or votes; start in RESULTADO clears listo and counts at the next edge and opens a new session.
